tx_word_serializer: RTL and testbench
=====================================

// Module: tx_word_serializer
// PURPOSE
//  TX-path stage directly upstream of the scrambler. Accepts parallel words over a valid/ready
//  interface, buffers them in a small FIFO and turns each word into one scrambler burst:
//  a one-cycle start pulse, then WORD_W serial bits, then a wait for the scrambler's done.
//  One word becomes one scrambled frame on the line.
// PARAMETERS
//  WORD_W      32  bits per frame; equals scrambler burst length (32)
//  FIFO_DEPTH  4   input FIFO entries; power of 2, >=2
//  MSB_FIRST   1   1: s_data[WORD_W-1] serialized first; 0: s_data[0] first
// PORTS
//  clk        in   1                   single clock, rising edge
//  rst_n      in   1                   asynchronous, active-low reset
//  s_data     in   WORD_W              parallel word to transmit
//  s_valid    in   1                   s_data valid
//  s_ready    out  1                   FIFO can accept (= !full)
//  scr_start  out  1                   one-cycle pulse -> scrambler start
//  scr_in     out  1                   serial data bit -> scrambler in
//  scr_done   in   1                   scrambler done (high when idle/burst finished)
//  busy       out  1                   high in any state except IDLE
//  frame_cnt  out  16                  frames launched; wraps 0xFFFF->0x0000
// BEHAVIOUR
//  - Reset (async assert, sync-released use): FIFO emptied; state IDLE; s_ready=1, scr_start=0,
//    scr_in=0, busy=0, frame_cnt=0, bit counter=0. Asserting rst_n mid-frame aborts the frame
//    immediately; the word is lost, no partial bits after reset.
//  - Push: s_valid&&s_ready at posedge writes the FIFO. s_valid with s_ready=0 is ignored; the
//    producer holds data. No bypass: a pushed word is poppable the next cycle.
//  - Push and pop in the same cycle are both honoured; the count is unchanged. Full: s_ready=0.
//  - FSM (registered outputs):
//    IDLE : scr_start=0, scr_in=0. If FIFO non-empty: pop into shift reg, ->START.
//    START: scr_start=1 (this cycle only), scr_in=0; frame_cnt++; bit_cnt<=0; ->SHIFT.
//    SHIFT: scr_in=shreg[WORD_W-1] (MSB_FIRST) or shreg[0]; shift 1 per cycle; bit_cnt++;
//           at bit_cnt==WORD_W-1 (last bit driven) ->GAP. Exactly WORD_W cycles in SHIFT.
//    GAP  : scr_in=0; if scr_done==1 ->IDLE, else stay (no timeout).
//  - Latency: push at cycle T -> pop T+1 -> scr_start T+2 -> first bit T+3 ... last bit T+2+WORD_W.
//  - Minimum frame period: WORD_W+3 cycles (START, WORD_W x SHIFT, GAP, IDLE).
//  - bit_cnt width: $clog2(WORD_W); compare against WORD_W-1 only, no wrap reliance.
//  - FIFO pointers: $clog2(FIFO_DEPTH)+1 bits, wrap naturally; full = MSBs differ and rest equal.
//  - scr_done is ignored outside GAP. A low scr_done in GAP stalls indefinitely; the FIFO keeps
//    accepting until full.
// STRUCTURE
//  - serdes_tx_pkg: tx_ser_state_e {IDLE,START,SHIFT,GAP}; WORD_W_DEFAULT=32;
//    FRAME_CNT_W=16.
//  - Sub-module tx_sync_fifo (WIDTH, DEPTH): push/pop/full/empty/rdata, with the same
//    clk/rst_n as this block.
//  - Top: FSM, shift register, bit counter, frame counter.
// TESTING
//  1 Reset: rst_n=0 -> s_ready=1, scr_start=0, scr_in=0, busy=0, frame_cnt=0.
//  2 Single word 0xA5A50F0F pushed at cycle 0, scr_done tied 1 -> scr_start high only at
//    cycle 2; scr_in at cycles 3..34 = 1,0,1,0,0,1,0,1,... ending ...,1,1,1,1; frame_cnt=1;
//    busy=0 from cycle 36.
//  3 Back-pressure: push every cycle from 0, scr_done=1 -> 5 words accepted (cycles 0..4);
//    s_ready=0 from cycle 5; 6th word accepted only after the 2nd pop (cycle 36).
//  4 GAP stall: hold scr_done=0 through cycle 50 -> FSM stays in GAP, scr_in=0, no new
//    scr_start; scr_done=1 at cycle 51 -> IDLE 52, next scr_start at cycle 54.
//  5 MSB_FIRST=0, word 0x00000001 -> scr_in=1 at first SHIFT cycle, 0 for the remaining 31.
//  6 Reset mid-SHIFT (bit 10 of frame, 2 words queued) -> outputs zero in the same cycle;
//    after release FIFO empty, no scr_start until a new push; frame_cnt=0.

Source files
------------

// File: rtl/serdes_tx_pkg.sv
// Purpose: shared types and constants for the TX word serializer slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package serdes_tx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        SHIFT = 2'd2,
        GAP   = 2'd3
    } tx_ser_state_e;

    localparam int WORD_W_DEFAULT = 32;
    localparam int FRAME_CNT_W    = 16;

endpackage

// File: rtl/tx_sync_fifo.sv
// Purpose: small synchronous FIFO with show-ahead read data, no write-to-read bypass.
// Latency: a word pushed at edge T is visible on rdata / poppable from edge T+1.
// Backpressure: pushes while full are dropped (caller gates with !full); pops while empty ignored.
module tx_sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Extra pointer MSB tells a full ring from an empty one.
    assign full    = (wr_ptr[PW-1] != rd_ptr[PW-1]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty   = (wr_ptr == rd_ptr);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr[AW-1:0]];

    // Storage array; contents need no reset since the pointers gate visibility.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= wdata;
        end
    end

    // Read/write pointers, free-running and wrapping naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
        end
    end

endmodule

// File: rtl/tx_word_serializer.sv
// Purpose: buffer parallel words and emit each as a scrambler burst (start pulse + WORD_W serial bits).
// Latency: push at edge T -> pop T+1 -> scr_start after T+2 -> first bit after T+3.
// Backpressure: s_ready = !fifo_full; a low scr_done in GAP stalls the FSM while the FIFO keeps filling.
module tx_word_serializer
    import serdes_tx_pkg::*;
#(
    parameter int WORD_W     = WORD_W_DEFAULT,
    parameter int FIFO_DEPTH = 4,
    parameter bit MSB_FIRST  = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [WORD_W-1:0]      s_data,
    input  logic                   s_valid,
    output logic                   s_ready,
    output logic                   scr_start,
    output logic                   scr_in,
    input  logic                   scr_done,
    output logic                   busy,
    output logic [FRAME_CNT_W-1:0] frame_cnt
);

    localparam int             CNT_W    = $clog2(WORD_W);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_W - 1);

    tx_ser_state_e     state;
    tx_ser_state_e     state_nxt;
    logic              pop;
    logic              push;
    logic              fifo_full;
    logic              fifo_empty;
    logic [WORD_W-1:0] fifo_rdata;
    logic [WORD_W-1:0] shreg;
    logic [CNT_W-1:0]  bit_cnt;
    logic              ser_bit;

    assign s_ready = !fifo_full;
    assign push    = s_valid && s_ready;
    assign ser_bit = MSB_FIRST ? shreg[WORD_W-1] : shreg[0];

    tx_sync_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wdata (s_data),
        .pop   (pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode; the pop is taken only on the IDLE->START transition.
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    state_nxt = START;
                end
            end
            START: state_nxt = SHIFT;
            SHIFT: begin
                if (bit_cnt == LAST_BIT) state_nxt = GAP;
            end
            GAP: begin
                if (scr_done) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: shift register, bit/frame counters and registered scrambler-side outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg     <= '0;
            bit_cnt   <= '0;
            frame_cnt <= '0;
            scr_start <= 1'b0;
            scr_in    <= 1'b0;
            busy      <= 1'b0;
        end else begin
            scr_start <= (state == START);
            scr_in    <= (state == SHIFT) ? ser_bit : 1'b0;
            busy      <= (state != IDLE);
            if (pop) begin
                shreg <= fifo_rdata;
            end else if (state == SHIFT) begin
                shreg <= MSB_FIRST ? {shreg[WORD_W-2:0], 1'b0} : {1'b0, shreg[WORD_W-1:1]};
            end
            if (state == START) begin
                bit_cnt   <= '0;
                frame_cnt <= frame_cnt + FRAME_CNT_W'(1);
            end else if (state == SHIFT) begin
                bit_cnt <= bit_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_tx_word_serializer.sv
// Purpose: randomized scoreboard bench for tx_word_serializer plus directed timing/boundary cases.
// Latency: expected frames are queued at push time and matched when scr_start appears.
// Backpressure: the driver only queues words it saw accepted (s_valid && s_ready before the edge).
module tb_tx_word_serializer;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [W-1:0]  s_data;
    logic          s_valid;
    logic          s_ready;
    logic          scr_start;
    logic          scr_in;
    logic          scr_done;
    logic          busy;
    logic [15:0]   frame_cnt;

    logic [W-1:0]  l_data;
    logic          l_valid;
    logic          l_ready;
    logic          l_start;
    logic          l_in;
    logic          l_done;
    logic          l_busy;
    logic [15:0]   l_fc;

    int            checks   = 0;
    int            failures = 0;
    logic [W-1:0]  exp_q[$];
    int            exp_frames = 0;
    int            bits_left  = 0;
    logic [W-1:0]  cur;

    always #5 clk = ~clk;

    tx_word_serializer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .s_data    (s_data),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .scr_start (scr_start),
        .scr_in    (scr_in),
        .scr_done  (scr_done),
        .busy      (busy),
        .frame_cnt (frame_cnt)
    );

    tx_word_serializer #(.MSB_FIRST(1'b0)) dut_lsb (
        .clk       (clk),
        .rst_n     (rst_n),
        .s_data    (l_data),
        .s_valid   (l_valid),
        .s_ready   (l_ready),
        .scr_start (l_start),
        .scr_in    (l_in),
        .scr_done  (l_done),
        .busy      (l_busy),
        .frame_cnt (l_fc)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One driver cycle: offer a word, record it as expected if the DUT can take it.
    task automatic drive(input logic v, input logic [W-1:0] d, output logic acc);
        s_valid = v;
        s_data  = d;
        acc     = v && s_ready;
        if (acc) exp_q.push_back(d);
        tick();
        s_valid = 1'b0;
    endtask

    task automatic wait_idle(input int lim);
        int k = 0;
        while ((exp_q.size() != 0 || busy || bits_left != 0) && k < lim) begin
            tick();
            k++;
        end
        chk("drain_within_bound", (k < lim), 1'b1);
    endtask

    // Monitor: each scr_start opens a frame whose WORD_W bits must equal the next queued word, MSB first.
    always @(negedge clk) begin
        if (!rst_n) begin
            bits_left  = 0;
            exp_frames = 0;
            exp_q.delete();
        end else if (bits_left > 0) begin
            chk("start_inside_burst", scr_start, 1'b0);
            chk("scr_in_bit", scr_in, cur[W-1]);
            cur       = cur << 1;
            bits_left = bits_left - 1;
        end else begin
            chk("scr_in_outside_burst", scr_in, 1'b0);
            if (scr_start) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_start: scr_start=1 with no queued word at %0t", $time);
                end else begin
                    cur        = exp_q.pop_front();
                    bits_left  = W;
                    exp_frames = exp_frames + 1;
                    chk("frame_cnt", frame_cnt, 64'(exp_frames % 65536));
                end
            end
        end
    end

    initial begin
        #2_000_000;
        failures++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        logic         acc;
        int           n;
        int           acc_cnt;
        int           sixth;
        logic [15:0]  fc0;
        logic [W-1:0] w;

        rst_n    = 1'b0;
        s_valid  = 1'b0;
        s_data   = '0;
        scr_done = 1'b1;
        l_valid  = 1'b0;
        l_data   = '0;
        l_done   = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // Reset values
        chk("rst_s_ready", s_ready, 1'b1);
        chk("rst_scr_start", scr_start, 1'b0);
        chk("rst_scr_in", scr_in, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_frame_cnt", frame_cnt, 16'h0);
        rst_n = 1'b1;
        tick();
        tick();

        // Single word: start two edges after the push, idle again 36 edges after it
        drive(1'b1, 32'hA5A50F0F, acc);
        chk("t2_accept", acc, 1'b1);
        n = 0;
        while (!scr_start && n < 100) begin tick(); n++; end
        chk("t2_start_latency", n, 2);
        chk("t2_busy_during_frame", busy, 1'b1);
        while (busy && n < 100) begin tick(); n++; end
        chk("t2_busy_fall_edge", n, 36);
        chk("t2_frame_cnt", frame_cnt, 16'd1);
        wait_idle(100);

        // Back-pressure: offer every cycle; 5 accepted on edges 0..4, 6th after the second pop
        acc_cnt = 0;
        sixth   = -1;
        for (int e = 0; e < 80 && acc_cnt < 6; e++) begin
            if (e == 5) chk("t3_ready_low_when_full", s_ready, 1'b0);
            drive(1'b1, $urandom, acc);
            if (acc) begin
                acc_cnt++;
                if (acc_cnt == 5) chk("t3_fifth_accept_edge", e, 4);
                if (acc_cnt == 6) sixth = e;
            end
        end
        chk("t3_sixth_accept_edge", sixth, 37);
        wait_idle(600);

        // GAP stall: scr_done low holds the FSM, no new start, no serial data
        scr_done = 1'b0;
        drive(1'b1, $urandom, acc);
        drive(1'b1, $urandom, acc);
        n = 0;
        while (!scr_start && n < 20) begin tick(); n++; end
        chk("t4_first_start_seen", scr_start, 1'b1);
        fc0 = frame_cnt;
        for (int i = 0; i < 45; i++) begin
            tick();
            chk("t4_no_start_in_stall", scr_start, 1'b0);
        end
        chk("t4_busy_in_stall", busy, 1'b1);
        chk("t4_frame_cnt_hold", frame_cnt, fc0);
        scr_done = 1'b1;
        n = 0;
        while (!scr_start && n < 20) begin tick(); n++; end
        chk("t4_restart_latency", n, 3);
        wait_idle(200);

        // LSB-first instance
        for (int k = 0; k < 2; k++) begin
            w = (k == 0) ? 32'h0000_0001 : W'($urandom);
            chk("t5_lsb_ready", l_ready, 1'b1);
            l_data  = w;
            l_valid = 1'b1;
            tick();
            l_valid = 1'b0;
            n = 0;
            while (!l_start && n < 10) begin tick(); n++; end
            chk("t5_lsb_start", l_start, 1'b1);
            for (int i = 0; i < W; i++) begin
                tick();
                chk("t5_lsb_bit", l_in, w[i]);
            end
            repeat (4) tick();
        end
        chk("t5_lsb_frames", l_fc, 16'd2);
        chk("t5_lsb_idle", l_busy, 1'b0);

        // Reset in the middle of SHIFT with words still queued
        drive(1'b1, $urandom, acc);
        drive(1'b1, $urandom, acc);
        drive(1'b1, $urandom, acc);
        n = 0;
        while (!scr_start && n < 20) begin tick(); n++; end
        repeat (10) tick();
        rst_n = 1'b0;
        #1;
        chk("t6_rst_scr_in", scr_in, 1'b0);
        chk("t6_rst_scr_start", scr_start, 1'b0);
        chk("t6_rst_busy", busy, 1'b0);
        chk("t6_rst_frame_cnt", frame_cnt, 16'h0);
        chk("t6_rst_s_ready", s_ready, 1'b1);
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("t6_no_start_after_reset", scr_start, 1'b0);
        end
        chk("t6_idle_after_reset", busy, 1'b0);
        chk("t6_frame_cnt_after_reset", frame_cnt, 16'h0);
        drive(1'b1, 32'h1234_5678, acc);
        wait_idle(100);
        chk("t6_frame_cnt_new_push", frame_cnt, 16'd1);

        // Randomized traffic with random scrambler stalls
        for (int c = 0; c < 1500; c++) begin
            scr_done = (($urandom % 4) != 0);
            drive(1'($urandom % 2), W'($urandom), acc);
        end
        scr_done = 1'b1;
        wait_idle(2000);
        chk("end_queue_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
